// File: rtl/csr_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_regfile_if
// Description : CSR access bus between the execute stage (master) and the
//               machine-mode CSR register file (slave). The write strobe,
//               address and write data go to the CSR block; the
//               combinational read data and the illegal-access flag come back.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_regfile_if;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_data_i;
  logic [63:0] csr_data_o;
  logic        csr_illegal_o;

  modport master (
    output csr_we_i, csr_addr_i, csr_data_i,
    input  csr_data_o, csr_illegal_o
  );

  modport slave (
    input  csr_we_i, csr_addr_i, csr_data_i,
    output csr_data_o, csr_illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/csr_regfile.sv
`default_nettype none
// ============================================================================
// Module      : csr_regfile
// Description : RV64 machine-mode CSR register file. Provides mstatus, misa,
//               mie, mtvec, mscratch, mepc, mcause, mtval, mip and mhartid,
//               plus trap entry and MRET handling. Updates are prioritised
//               trap > mret > CSR write.
//               Optional macro CSR_COUNTER_EN adds the mcycle/minstret
//               counters; without it 0xB00/0xB02 read 0 and ignore writes.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_regfile (
  input  logic                clk,
  input  logic                rst,
  csr_regfile_if.slave        bus,
  input  logic                instr_retire_i,
  input  logic                mret_i,
  input  logic                trap_valid_i,
  input  logic [63:0]         trap_pc_i,
  input  logic [63:0]         trap_cause_i,
  input  logic [63:0]         trap_val_i,
  input  logic                timer_irq_i,
  input  logic                ext_irq_i,
  output logic [63:0]         mtvec_o,
  output logic [63:0]         mepc_o,
  output logic                irq_pending_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [63:0] MISA_VALUE    = 64'h8000_0000_0000_0100;
  localparam logic [63:0] ALIGN_MASK    = ~64'h3;

  // Architectural state
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_mtie;
  logic        mie_meie;
  logic        mip_mtip;
  logic        mip_meip;
  logic [63:0] mtvec_reg;
  logic [63:0] mscratch_reg;
  logic [63:0] mepc_reg;
  logic [63:0] mcause_reg;
  logic [63:0] mtval_reg;

  // Access decode
  logic        addr_impl;
  logic        ro_write;
  logic        wr_ok;
  logic [63:0] rd_data;
  logic [63:0] wdata;

  assign wdata    = bus.csr_data_i;
  // Bits [11:10] == 2'b11 mark the read-only CSR space.
  assign ro_write = bus.csr_we_i & (bus.csr_addr_i[11:10] == 2'b11);
  assign wr_ok    = bus.csr_we_i & ~ro_write;

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle_reg;
  logic [63:0] minstret_reg;

  // Free-running cycle counter; a CSR write replaces this cycle's increment.
  always_ff @(posedge clk) begin
    if (rst)
      mcycle_reg <= '0;
    else if (wr_ok && bus.csr_addr_i == ADDR_MCYCLE)
      mcycle_reg <= wdata;
    else
      mcycle_reg <= mcycle_reg + 64'd1;
  end

  // Retired-instruction counter; a CSR write replaces this cycle's increment.
  always_ff @(posedge clk) begin
    if (rst)
      minstret_reg <= '0;
    else if (wr_ok && bus.csr_addr_i == ADDR_MINSTRET)
      minstret_reg <= wdata;
    else if (instr_retire_i)
      minstret_reg <= minstret_reg + 64'd1;
  end
`else
  // Retire strobe has no consumer when the counters are compiled out.
  logic unused_retire;
  assign unused_retire = instr_retire_i;
`endif

  // Combinational read mux and implemented-address decode.
  always_comb begin
    rd_data   = '0;
    addr_impl = 1'b1;
    case (bus.csr_addr_i)
      ADDR_MSTATUS:  rd_data = {51'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      ADDR_MISA:     rd_data = MISA_VALUE;
      ADDR_MIE:      rd_data = {52'b0, mie_meie, 3'b0, mie_mtie, 7'b0};
      ADDR_MTVEC:    rd_data = mtvec_reg;
      ADDR_MSCRATCH: rd_data = mscratch_reg;
      ADDR_MEPC:     rd_data = mepc_reg;
      ADDR_MCAUSE:   rd_data = mcause_reg;
      ADDR_MTVAL:    rd_data = mtval_reg;
      ADDR_MIP:      rd_data = {52'b0, mip_meip, 3'b0, mip_mtip, 7'b0};
`ifdef CSR_COUNTER_EN
      ADDR_MCYCLE:   rd_data = mcycle_reg;
      ADDR_MINSTRET: rd_data = minstret_reg;
`else
      ADDR_MCYCLE:   rd_data = '0;
      ADDR_MINSTRET: rd_data = '0;
`endif
      ADDR_MHARTID:  rd_data = '0;
      default:       addr_impl = 1'b0;
    endcase
  end

  assign bus.csr_data_o    = rd_data;
  assign bus.csr_illegal_o = ~addr_impl | ro_write;

  // mstatus MIE/MPIE: trap stacks MIE, mret unstacks it, CSR write lowest.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap_valid_i) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_ok && bus.csr_addr_i == ADDR_MSTATUS) begin
      mstatus_mie  <= wdata[3];
      mstatus_mpie <= wdata[7];
    end
  end

  // Trap-captured registers; a trap wins over a same-cycle CSR write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_reg   <= '0;
      mcause_reg <= '0;
      mtval_reg  <= '0;
    end else if (trap_valid_i) begin
      mepc_reg   <= trap_pc_i & ALIGN_MASK;
      mcause_reg <= trap_cause_i;
      mtval_reg  <= trap_val_i;
    end else if (wr_ok) begin
      if (bus.csr_addr_i == ADDR_MEPC)   mepc_reg   <= wdata & ALIGN_MASK;
      if (bus.csr_addr_i == ADDR_MCAUSE) mcause_reg <= wdata;
      if (bus.csr_addr_i == ADDR_MTVAL)  mtval_reg  <= wdata;
    end
  end

  // Software-only registers: mtvec (direct mode), mscratch, mie enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtvec_reg    <= '0;
      mscratch_reg <= '0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
    end else if (wr_ok) begin
      if (bus.csr_addr_i == ADDR_MTVEC)    mtvec_reg    <= wdata & ALIGN_MASK;
      if (bus.csr_addr_i == ADDR_MSCRATCH) mscratch_reg <= wdata;
      if (bus.csr_addr_i == ADDR_MIE) begin
        mie_mtie <= wdata[7];
        mie_meie <= wdata[11];
      end
    end
  end

  // mip tracks the interrupt lines one cycle late; software cannot write it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mip_mtip <= 1'b0;
      mip_meip <= 1'b0;
    end else begin
      mip_mtip <= timer_irq_i;
      mip_meip <= ext_irq_i;
    end
  end

  assign mtvec_o       = mtvec_reg;
  assign mepc_o        = mepc_reg;
  assign irq_pending_o = mstatus_mie & ((mie_mtie & mip_mtip) | (mie_meie & mip_meip));

endmodule
`default_nettype wire
